irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- External interrupt front-end placed directly upstream of the CP0 block.
- Synchronises up to N asynchronous interrupt lines and edge-detects them into a pending register.
- Applies a software-writable mask and selects the lowest-numbered enabled pending line.
- Presents a single request plus cause index to CP0, holds it until CP0 acknowledges, then blocks further requests until ERET.

Parameters:
- N_IRQ, 8, number of external interrupt lines.
- CAUSE_W, 3, width of cause index; must satisfy 2^CAUSE_W >= N_IRQ.
- SYNC_STAGES, 2, flops in each input synchroniser (>= 2).

Ports:
- clk  in  1  main clock.
- rst  in  1  asynchronous active-high reset.
- irq_lines  in  N_IRQ  raw asynchronous interrupt inputs; active-high.
- mask_we  in  1  mask register write strobe (MTC0 decode).
- mask_wdata  in  N_IRQ  new mask value; 1 = enabled.
- mask_rdata  out  N_IRQ  current mask.
- pending  out  N_IRQ  current pending register.
- int_ack  in  1  CP0 took the interrupt (ir-authorised jump), one-cycle pulse.
- int_eret  in  1  ERET executed, one-cycle pulse.
- ir_req  out  1  interrupt request to CP0 ir_in; registered.
- int_cause  out  CAUSE_W  index of the requested line; registered; valid while ir_req=1.
- in_service  out  1  high from ack until ERET.

Behaviour:
- Reset (async, active-high): synchroniser flops, edge-history flops, pending, state and ir_req all clear to 0. mask clears to all-zero, i.e. all lines masked. int_cause resets to 0. in_service resets to 0.
- Synchroniser: SYNC_STAGES flops per line; s = last stage; s_d = s delayed one clock; edge = s & ~s_d.
- Pending, per bit, at each posedge:
  - Set if edge=1.
  - Else clear if (state=REQ & int_ack & bit==latched index).
  - Set wins over a same-cycle clear.
- Mask: loaded with mask_wdata at the posedge where mask_we=1. Masking affects selection only; it never clears pending.
- Selection: lowest index i with pending[i] & mask[i]; combinational from registered state.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE, any enabled pending: go to REQ; latch the selected index into int_cause; ir_req<=1.
  - REQ, int_ack: clear pending[int_cause]; go to SERVICE; ir_req<=0; in_service<=1.
  - REQ, latched line now disabled (mask bit 0 after a write) and no int_ack: withdraw; go to IDLE; ir_req<=0.
  - REQ, int_ack and a mask write in the same cycle: ack wins.
  - REQ, index is locked; a higher-priority line arriving does not re-arbitrate.
  - SERVICE: ir_req held 0, so there is no nesting. int_eret goes to IDLE; in_service<=0.
  - int_eret outside SERVICE: ignored.
  - int_ack outside REQ: ignored.
- Latency: the line must be stable high before sampling edge E1. Then:
  - s=1 after E2.
  - pending=1 after E3.
  - ir_req=1 after E4.
  - Total: 4 clocks with SYNC_STAGES=2.
- Back-to-back after ERET: IDLE re-arbitrates on the next clock. If pending remains, ir_req rises 1 clock after returning to IDLE.
- A level held high produces one pending event only; a new event needs a low period of at least 1 synchronised clock.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and default N_IRQ/CAUSE_W constants.
- Sub-module irq_sync: one parameterised synchroniser plus edge detector, instantiated per line via generate.
- Pending, mask, priority encoder and FSM stay in the top.

Test Plan:
- Reset, then mask=8'hFF, pulse irq_lines[5] for 3 clocks -> pending=8'h20 after E3; ir_req=1 with int_cause=5 after E4; pulse int_ack -> pending=0, in_service=1, ir_req=0.
- Lines 2 and 6 rise in the same cycle with mask=8'hFF -> int_cause=2. Ack, then int_eret -> within 2 clocks ir_req=1 with int_cause=6.
- mask=8'h00 and pulse line 3 -> pending=8'h08, ir_req stays 0. Write mask=8'h08 -> ir_req=1, int_cause=3 one clock after the write.
- In REQ for line 4, write mask=8'hEF without ack -> ir_req=0 next clock, state IDLE, pending[4] still 1.
- In REQ for line 1, a new rising edge of line 1 lands in the same cycle as int_ack -> pending[1] stays 1, SERVICE entered; after ERET, line 1 is re-requested.
- Assert rst asynchronously mid-SERVICE (between clock edges) -> ir_req, in_service, pending and mask read 0 immediately; int_eret after reset is ignored.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the external interrupt front-end:
// FSM state encoding and default sizing constants.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int N_IRQ_DEF       = 8;
  localparam int CAUSE_W_DEF     = 3;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/irq_ctrl_sync.sv
// Per-line synchroniser chain followed by a rising-edge detector
// on the last synchronised stage.
module irq_sync
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front-end for CP0: synchronise and edge-detect lines into a
// pending register, mask, pick the lowest enabled line and hand it to CP0.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int CAUSE_W     = CAUSE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IRQ-1:0]   irq_lines,
  input  logic               mask_we,
  input  logic [N_IRQ-1:0]   mask_wdata,
  output logic [N_IRQ-1:0]   mask_rdata,
  output logic [N_IRQ-1:0]   pending,
  input  logic               int_ack,
  input  logic               int_eret,
  output logic               ir_req,
  output logic [CAUSE_W-1:0] int_cause,
  output logic               in_service
);

  logic [N_IRQ-1:0]   rise_s;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q;
  logic [N_IRQ-1:0]   enabled_s;
  logic [CAUSE_W-1:0] sel_idx_s;
  logic               sel_any_s;
  logic               ack_clr_s;
  state_e             state_q, state_d;
  logic               ir_req_q, ir_req_d;
  logic               in_service_q, in_service_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (irq_lines[g]),
      .rise_o (rise_s[g])
    );
  end

  assign enabled_s = pending_q & mask_q;
  assign sel_any_s = |enabled_s;
  assign ack_clr_s = (state_q == ST_REQ) && int_ack;

  always_comb begin
    sel_idx_s = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (enabled_s[i]) begin
        sel_idx_s = CAUSE_W'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // A new edge always wins over the ack clearing the same bit.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      pending_d[i] = rise_s[i] |
                     (pending_q[i] & ~(ack_clr_s && (cause_q == CAUSE_W'(i))));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end else begin
        mask_q <= mask_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any_s) state_d = ST_REQ;
        else           state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (int_ack)               state_d = ST_SERVICE;
        else if (!mask_q[cause_q]) state_d = ST_IDLE;
        else                       state_d = ST_REQ;
      end
      ST_SERVICE: begin
        if (int_eret) state_d = ST_IDLE;
        else          state_d = ST_SERVICE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The cause index is locked only on the IDLE->REQ transition.
  always_comb begin
    ir_req_d     = (state_d == ST_REQ);
    in_service_d = (state_d == ST_SERVICE);
    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
      cause_d = sel_idx_s;
    end else begin
      cause_d = cause_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ir_req_q     <= 1'b0;
      in_service_q <= 1'b0;
      cause_q      <= '0;
    end else begin
      state_q      <= state_d;
      ir_req_q     <= ir_req_d;
      in_service_q <= in_service_d;
      cause_q      <= cause_d;
    end
  end

  assign mask_rdata = mask_q;
  assign pending    = pending_q;
  assign ir_req     = ir_req_q;
  assign int_cause  = cause_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected causes, a monitor
// pops one on every rising ir_req; status outputs are checked directly.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_lines;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask_rdata;
  logic [7:0] pending;
  logic       int_ack;
  logic       int_eret;
  logic       ir_req;
  logic [2:0] int_cause;
  logic       in_service;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  logic prev_req = 1'b0;

  irq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_lines  (irq_lines),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_rdata (mask_rdata),
    .pending    (pending),
    .int_ack    (int_ack),
    .int_eret   (int_eret),
    .ir_req     (ir_req),
    .int_cause  (int_cause),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic eret();
    int_eret = 1'b1;
    tick();
    int_eret = 1'b0;
  endtask

  // Monitor: every new request must match the oldest expected cause.
  always @(negedge clk) begin
    if (ir_req && !prev_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_req: got cause %0d expected no request at %0t", int_cause, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int_cause !== 3'(e)) begin
          failures++;
          $display("FAIL req_cause: got %0d expected %0d at %0t", int_cause, e, $time);
        end
      end
    end
    prev_req <= ir_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_lines = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
    int_ack = 1'b0; int_eret = 1'b0;
    tick(); tick();
    chk("rst_ir_req", {7'd0, ir_req}, 8'h00);
    chk("rst_pending", pending, 8'h00);
    chk("rst_mask", mask_rdata, 8'h00);
    chk("rst_cause", {5'd0, int_cause}, 8'h00);
    chk("rst_in_service", {7'd0, in_service}, 8'h00);
    rst = 1'b0;
    tick();

    // Single line 5, latency E3/E4, then ack
    write_mask(8'hFF);
    chk("mask_ff", mask_rdata, 8'hFF);
    irq_lines = 8'h20; exp_q.push_back(5);
    tick(); tick(); tick();
    chk("t1_pending_e3", pending, 8'h20);
    chk("t1_req_e3", {7'd0, ir_req}, 8'h00);
    irq_lines = 8'h00;
    tick();
    chk("t1_req_e4", {7'd0, ir_req}, 8'h01);
    ack();
    chk("t1_pending_ack", pending, 8'h00);
    chk("t1_in_service", {7'd0, in_service}, 8'h01);
    chk("t1_req_ack", {7'd0, ir_req}, 8'h00);
    eret();
    chk("t1_eret", {7'd0, in_service}, 8'h00);
    tick();

    // Lines 2 and 6 together: priority then back-to-back after ERET
    irq_lines = 8'h44; exp_q.push_back(2); exp_q.push_back(6);
    repeat (4) tick();
    irq_lines = 8'h00;
    chk("t2_req", {7'd0, ir_req}, 8'h01);
    ack();
    chk("t2_pending", pending, 8'h40);
    eret();
    tick();
    chk("t2_b2b_req", {7'd0, ir_req}, 8'h01);
    ack(); eret();
    chk("t2_pending_end", pending, 8'h00);

    // Masked line 3, then enable it
    write_mask(8'h00);
    irq_lines = 8'h08;
    tick(); tick(); tick();
    irq_lines = 8'h00;
    chk("t3_pending", pending, 8'h08);
    tick();
    chk("t3_masked_req", {7'd0, ir_req}, 8'h00);
    exp_q.push_back(3);
    write_mask(8'h08);
    chk("t3_req_at_write", {7'd0, ir_req}, 8'h00);
    tick();
    chk("t3_req_after", {7'd0, ir_req}, 8'h01);
    ack(); eret();

    // Withdraw line 4 by masking it while in REQ
    write_mask(8'hFF);
    irq_lines = 8'h10; exp_q.push_back(4);
    repeat (4) tick();
    irq_lines = 8'h00;
    chk("t4_req", {7'd0, ir_req}, 8'h01);
    write_mask(8'hEF);
    tick();
    chk("t4_withdrawn", {7'd0, ir_req}, 8'h00);
    chk("t4_not_service", {7'd0, in_service}, 8'h00);
    chk("t4_pending_kept", pending, 8'h10);
    exp_q.push_back(4);
    write_mask(8'hFF);
    tick();
    chk("t4_rerequest", {7'd0, ir_req}, 8'h01);
    ack(); eret();

    // New edge on line 1 coincides with the ack
    irq_lines = 8'h02; exp_q.push_back(1);
    tick();
    irq_lines = 8'h00;
    tick();
    irq_lines = 8'h02;
    tick(); tick();
    chk("t5_req", {7'd0, ir_req}, 8'h01);
    ack();
    irq_lines = 8'h00;
    chk("t5_pending_kept", pending, 8'h02);
    chk("t5_service", {7'd0, in_service}, 8'h01);
    exp_q.push_back(1);
    eret();
    tick();
    chk("t5_rerequest", {7'd0, ir_req}, 8'h01);
    ack(); eret();
    chk("t5_pending_end", pending, 8'h00);

    // Asynchronous reset in SERVICE
    irq_lines = 8'h80; exp_q.push_back(7);
    repeat (4) tick();
    irq_lines = 8'h00;
    ack();
    chk("t6_service", {7'd0, in_service}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req", {7'd0, ir_req}, 8'h00);
    chk("t6_rst_service", {7'd0, in_service}, 8'h00);
    chk("t6_rst_pending", pending, 8'h00);
    chk("t6_rst_mask", mask_rdata, 8'h00);
    #1 rst = 1'b0;
    eret();
    chk("t6_eret_ignored", {7'd0, in_service}, 8'h00);
    tick();
    chk("t6_no_req", {7'd0, ir_req}, 8'h00);

    tick();
    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
